// File: rtl/cory_muxn_burst_pkg.sv
// Shared types and helpers for cory_muxn_burst: FSM state encoding,
// select-token field layout and the index-width function.
package cory_muxn_burst_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Select token layout is {len, idx}: idx sits at bit 0, len directly above it.
  localparam int SEL_IDX_LSB = 0;

  function automatic int sel_len_lsb(input int s);
    return s;
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cory_muxn_burst_queue.sv
// Output queue for cory_muxn_burst: D-entry circular buffer, or a plain
// wire-through when D is 0. Reset empties it.
module cory_muxn_burst_queue
  import cory_muxn_burst_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_v,
  input  logic [W-1:0] i_d,
  output logic         o_r,
  output logic         o_v,
  output logic [W-1:0] o_d,
  input  logic         i_r
);

  if (D == 0) begin : g_pass
    logic unused_s;
    assign unused_s = clk ^ reset_n;
    assign o_v      = i_v;
    assign o_d      = i_d;
    assign o_r      = i_r;
  end else begin : g_fifo
    localparam int PW = sel_width(D);
    localparam int CW = sel_width(D + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);
    localparam logic [CW-1:0] FULL     = CW'(D);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_s, pop_s;

    assign o_r    = (cnt_q != FULL);
    assign o_v    = (cnt_q != {CW{1'b0}});
    assign o_d    = mem_q[rd_q];
    assign push_s = i_v & o_r;
    assign pop_s  = o_v & i_r;

    // Pointer wrap and occupancy update.
    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_s) begin
        wr_d = (wr_q == PTR_LAST) ? {PW{1'b0}} : wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = (rd_q == PTR_LAST) ? {PW{1'b0}} : rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= {PW{1'b0}};
        rd_q  <= {PW{1'b0}};
        cnt_q <= {CW{1'b0}};
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_q[wr_q] <= i_d;
      end
    end
  end

endmodule

// File: rtl/cory_muxn_burst.sv
// M-input stream mux: a select token {len, idx} routes len+1 beats from input idx
// to the queued output. Define CORY_MUXN_BURST_B2B_EN to chain bursts with no bubble.
module cory_muxn_burst
  import cory_muxn_burst_pkg::*;
#(
  parameter  int N = 8,
  parameter  int M = 4,
  parameter  int L = 4,
  parameter  int Q = 0,
  localparam int S = sel_width(M)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [M-1:0]   i_a_v,
  input  logic [M*N-1:0] i_a_d,
  output logic [M-1:0]   o_a_r,
  input  logic           i_s_v,
  input  logic [S+L-1:0] i_s_d,
  output logic           o_s_r,
  output logic           o_z_v,
  output logic [N-1:0]   o_z_d,
  input  logic           i_z_r,
  output logic           o_err,
  output logic           o_busy
);

  localparam logic [S:0] M_LIM = (S + 1)'(M);

  state_e       state_q, state_d;
  logic [S-1:0] sel_q, sel_d;
  logic [L-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  logic [S-1:0] tok_idx_s;
  logic [L-1:0] tok_len_s;
  logic         tok_ok_s;
  logic         s_hs_s;
  logic         int_v_s;
  logic         int_r_s;
  logic [N-1:0] int_d_s;
  logic         beat_hs_s;
  logic         last_beat_s;

  assign tok_idx_s   = i_s_d[SEL_IDX_LSB +: S];
  assign tok_len_s   = i_s_d[sel_len_lsb(S) +: L];
  assign tok_ok_s    = ({1'b0, tok_idx_s} < M_LIM);
  assign s_hs_s      = i_s_v & o_s_r;
  assign beat_hs_s   = int_v_s & int_r_s;
  assign last_beat_s = beat_hs_s & (cnt_q == {L{1'b0}});

  // Route the selected channel onto the internal stream; nothing flows while idle.
  always_comb begin
    int_v_s = 1'b0;
    int_d_s = {N{1'b0}};
    for (int k = 0; k < M; k++) begin
      int_v_s = int_v_s | (i_a_v[k] & (sel_q == S'(k)));
      int_d_s = int_d_s | (i_a_d[k*N +: N] & {N{sel_q == S'(k)}});
    end
    int_v_s = int_v_s & (state_q == ST_BURST);
  end

  // FSM state and selection registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= {S{1'b0}};
      cnt_q   <= {L{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: token decode in IDLE, beat counting in BURST.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_hs_s && tok_ok_s) begin
          state_d = ST_BURST;
          sel_d   = tok_idx_s;
          cnt_d   = tok_len_s;
        end else if (s_hs_s) begin
          err_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (last_beat_s) begin
`ifdef CORY_MUXN_BURST_B2B_EN
          // A token taken on the final beat reloads the burst in place.
          if (s_hs_s && tok_ok_s) begin
            sel_d   = tok_idx_s;
            cnt_d   = tok_len_s;
          end else if (s_hs_s) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else if (beat_hs_s) begin
          cnt_d = cnt_q - L'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs: only the selected channel is ever acknowledged.
  always_comb begin
    o_a_r = {M{1'b0}};
    o_s_r = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_s_r = 1'b1;
      end
      ST_BURST: begin
        for (int k = 0; k < M; k++) begin
          o_a_r[k] = int_r_s & (sel_q == S'(k));
        end
`ifdef CORY_MUXN_BURST_B2B_EN
        o_s_r = last_beat_s;
`else
        o_s_r = 1'b0;
`endif
      end
      default: begin
        o_s_r = 1'b0;
      end
    endcase
  end

  assign o_err  = err_q;
  assign o_busy = (state_q == ST_BURST);

  cory_muxn_burst_queue #(
    .W (N),
    .D (Q)
  ) u_cory_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .i_v     (int_v_s),
    .i_d     (int_d_s),
    .o_r     (int_r_s),
    .o_v     (o_z_v),
    .o_d     (o_z_d),
    .i_r     (i_z_r)
  );

`ifdef SIM
  cory_muxn_burst_chk #(
    .N (N)
  ) u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .z_v      (o_z_v),
    .z_r      (i_z_r),
    .z_d      (o_z_d),
    .burst    (state_q == ST_BURST),
    .cnt_zero (cnt_q == {L{1'b0}}),
    .beat     (beat_hs_s),
    .reload   (s_hs_s)
  );
`endif

endmodule

`ifdef SIM
// Protocol checks: output valid holds until accepted; the beat counter never wraps.
module cory_muxn_burst_chk #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         reset_n,
  input logic         z_v,
  input logic         z_r,
  input logic [N-1:0] z_d,
  input logic         burst,
  input logic         cnt_zero,
  input logic         beat,
  input logic         reload
);
  a_z_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (z_v && !z_r) |=> (z_v && $stable(z_d)));
  a_cnt_no_wrap: assert property (@(posedge clk) disable iff (!reset_n)
    (burst && cnt_zero && beat && !reload) |=> !burst);
endmodule
`endif
